// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a shared prescaler drives NUM_CH countdown timers whose
// expirations queue as one-deep pending events, drained round-robin over a valid/ready port.
module tick_scheduler #(
  parameter int PRESCALE = 100,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(NUM_CH)-1:0]  cmd_ch,
  input  logic [CNT_W-1:0]           cmd_period,
  input  logic                       cmd_periodic,
  output logic                       cmd_err,
  output logic                       evt_valid,
  output logic [$clog2(NUM_CH)-1:0]  evt_ch,
  input  logic                       evt_ready,
  output logic [NUM_CH-1:0]          running,
  output logic [NUM_CH-1:0]          overrun
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  logic [PS_W-1:0]   pre_cnt_reg;
  logic              base_tick;
  logic              bad_ch;
  logic              start_ok;
  logic              accept;
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   rr_reg;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W-1:0]   pick;
  logic              found;

  assign base_tick = (pre_cnt_reg == PS_W'(PRESCALE - 1));
  assign start_ok  = (cmd_op == OP_START) && (cmd_period != '0);
  assign accept    = evt_valid && evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pre_cnt_reg <= '0;
    else if (base_tick) pre_cnt_reg <= '0;
    else                pre_cnt_reg <= pre_cnt_reg + 1'b1;
  end

  // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full
      assign bad_ch = 1'b0;
    end else begin : g_part
      assign bad_ch = (cmd_ch >= CH_W'(NUM_CH));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_err <= 1'b0;
    else     cmd_err <= cmd_valid && (bad_ch || ((cmd_op == OP_START) && (cmd_period == '0)));
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t        state_reg, state_next;
      logic [CNT_W-1:0] remain_reg, remain_next;
      logic [CNT_W-1:0] period_reg, period_next;
      logic             periodic_reg, periodic_next;
      logic             pending_reg, pending_next;
      logic             overrun_reg, overrun_next;
      logic             hit, accept_me, expire;

      assign hit       = cmd_valid && !bad_ch && (cmd_ch == CH_W'(gi));
      assign accept_me = accept && (evt_ch == CH_W'(gi));

      // Commands take priority over a coincident base tick.
      always_comb begin
        state_next    = state_reg;
        remain_next   = remain_reg;
        period_next   = period_reg;
        periodic_next = periodic_reg;
        overrun_next  = overrun_reg;
        expire        = 1'b0;
        if (hit && start_ok) begin
          state_next    = RUN;
          remain_next   = cmd_period;
          period_next   = cmd_period;
          periodic_next = cmd_periodic;
        end else if (hit && (cmd_op == OP_STOP)) begin
          state_next = IDLE;
        end else if ((state_reg == RUN) && base_tick) begin
          if (remain_reg == CNT_W'(1)) begin
            expire = 1'b1;
            if (periodic_reg) remain_next = period_reg;
            else              state_next  = IDLE;
          end else begin
            remain_next = remain_reg - 1'b1;
          end
        end
        if (hit && (cmd_op == OP_CLR)) overrun_next = 1'b0;
        if (expire && pending_reg && !accept_me) overrun_next = 1'b1;
        pending_next = expire || (pending_reg && !accept_me);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg    <= IDLE;
          remain_reg   <= '0;
          period_reg   <= '0;
          periodic_reg <= 1'b0;
          pending_reg  <= 1'b0;
          overrun_reg  <= 1'b0;
        end else begin
          state_reg    <= state_next;
          remain_reg   <= remain_next;
          period_reg   <= period_next;
          periodic_reg <= periodic_next;
          pending_reg  <= pending_next;
          overrun_reg  <= overrun_next;
        end
      end

      assign running[gi] = (state_reg == RUN);
      assign overrun[gi] = overrun_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [CH_W:0] sum;
    logic [CH_W-1:0] idx;
    pick  = rr_reg;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_reg} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rr_next = (evt_ch == CH_W'(NUM_CH - 1)) ? '0 : evt_ch + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_reg    <= '0;
    end else if (evt_valid) begin
      if (evt_ready) begin
        evt_valid <= 1'b0;
        rr_reg    <= rr_next;
      end
    end else if (found) begin
      evt_valid <= 1'b1;
      evt_ch    <= pick;
    end
  end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel timer scheduler built around one shared free-running prescaler.
- The prescaler produces a base tick every PRESCALE clk cycles.
- Each of NUM_CH channels counts base ticks down from a programmed period, in one-shot or periodic mode.
- Expirations become pending events, drained one at a time through a round-robin arbitrated valid/ready event port to the control FSM.

Parameters:
- PRESCALE, 100, clk cycles per base tick (>=2).
- NUM_CH, 4, number of timer channels (2..16).
- CNT_W, 16, period/counter width in base ticks.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe; always accepted in the cycle it is high.
- cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 CLEAR_OVR.
- cmd_ch  in  clog2(NUM_CH)  target channel.
- cmd_period  in  CNT_W  period in base ticks (START only).
- cmd_periodic  in  1  1 = auto-reload, 0 = one-shot (START only).
- cmd_err  out  1  one-cycle pulse: START with period 0, or cmd_ch >= NUM_CH.
- evt_valid  out  1  event available.
- evt_ch  out  clog2(NUM_CH)  channel of presented event.
- evt_ready  in  1  consumer accepts event.
- running  out  NUM_CH  channel is in RUN.
- overrun  out  NUM_CH  sticky: channel expired while its event was still pending.

Behaviour:
- Reset (async): prescaler count, all channel counters, pending, running, overrun, rr pointer, evt_valid, evt_ch and cmd_err are cleared to 0.
- Prescaler:
  - Free-running 0..PRESCALE-1.
  - base_tick is an internal 1-cycle strobe when count == PRESCALE-1; count then wraps to 0.
  - Never stopped by channel state.
- Channel FSM (per channel), states IDLE and RUN:
  - START: load remain = cmd_period; store periodic flag; enter RUN. This also applies when the channel is already in RUN (restart; remaining count is discarded). Pending is untouched.
  - STOP: enter IDLE. Pending is untouched.
  - CLEAR_OVR: clear overrun[ch] only.
  - NOP: no effect.
  - RUN on base_tick with remain > 1: remain decrements.
  - RUN on base_tick with remain == 1 (expiry):
    - set pending[ch];
    - periodic: remain reloads the period and the channel stays in RUN;
    - one-shot: enter IDLE.
  - Expiry while pending[ch] already set and not being accepted in the same cycle: set overrun[ch]; pending stays 1. Only one event is ever queued per channel.
- Expiry timing:
  - First expiry occurs on the period-th base_tick strictly after the START cycle.
  - A base_tick coincident with the START cycle is not counted.
- cmd_err:
  - Bad START (period 0, or cmd_ch >= NUM_CH) leaves channel state unchanged.
  - Any command with cmd_ch >= NUM_CH is ignored and pulses cmd_err.
- Simultaneous events:
  - Command and base_tick on the same channel in the same cycle: the command wins. STOP suppresses the expiry; START restarts.
  - Acceptance of ch and new expiry of ch in the same cycle: pending stays 1, no overrun.
- Event port:
  - When evt_valid == 0 and any pending bit is set, the next edge loads evt_ch with the first pending channel at or after rr (wrapping) and raises evt_valid. This is 1 cycle of latency from pending set to evt_valid.
  - While evt_valid == 1 && evt_ready == 0, evt_ch and evt_valid are held stable. A STOP on that channel does not withdraw the event.
  - On evt_valid && evt_ready:
    - pending[evt_ch] clears (unless re-set by a simultaneous expiry);
    - rr becomes evt_ch+1, mod NUM_CH;
    - evt_valid drops for at least one cycle before the next event is presented.
- Widths: remain is CNT_W bits; the maximum period is 2^CNT_W-1. No arithmetic wrap is possible because remain never decrements below 1.
- Reset asserted mid-operation: all channels go to IDLE and any presented event is dropped with no acceptance required.

Test Plan (PRESCALE=4, NUM_CH=4, CNT_W=8):
- One-shot: START ch1 period 3 at cycle 0 -> expiry on the 3rd base_tick; evt_valid=1, evt_ch=1 one cycle later; running[1]=0; with evt_ready=1, evt_valid drops next cycle and no further events occur.
- Periodic + overrun: START ch0 period 2 periodic, evt_ready=0 -> first event presented; next expiry sets overrun[0]=1 and evt_valid stays 1 with evt_ch=0; CLEAR_OVR ch0 -> overrun[0]=0.
- Round robin: START ch0..ch3 all period 1 in the same cycle, evt_ready=1 -> events delivered in order 0,1,2,3, each separated by an evt_valid low cycle; a second identical burst starting at rr=0 repeats 0,1,2,3.
- Collisions: STOP ch2 in the exact cycle of its expiring base_tick -> no pending, no event, running[2]=0. START ch2 period 5 in a base_tick cycle -> expiry on the 5th later base_tick.
- Errors: START with period 0 -> cmd_err pulse, running unchanged. START cmd_ch=3 with period 0 -> no state change.
- Reset mid-run: ch0 and ch3 running with an event held (evt_ready=0), assert rst asynchronously -> all outputs 0 immediately; after release, no events until a new START.
